placar_display_scan: RTL and testbench

- Display back-end for the basketball scoreboard.
- Consumes the selected team score (7-bit binary) and the shot-clock value (5-bit binary), converts both to BCD with a sequential shift-add-3 engine, and time-multiplexes four common-anode 7-segment digits.
- Digits 3:2 show the score; digits 1:0 show the shot clock.
- Sits directly downstream of the score/shot-clock logic and drives board pins.

---
 rtl/placar_display_scan.sv | 142 ++++++++++++++
 tb/tb_placar_display_scan.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/placar_display_scan.sv
// Scoreboard display back-end: binary score/shot-clock to BCD via shift-add-3, 4-digit 7-seg scan.
// New digits commit 14 cycles after a frame start (or reset release); no backpressure, pins always driven.
module placar_display_scan #(
  parameter int SCAN_DIV      = 12500,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [6:0] score,
  input  logic [4:0] shot_clock,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       over99,
  output logic       conv_done
);

  localparam int            PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CONV_S, CONV_C, COMMIT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q;
  logic [1:0]      idx_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q, seg_d;
  logic            over99_q, conv_done_q;
  logic [3:0][3:0] dig_q;
  logic [2:0]      cnt_q, cnt_d;
  logic [14:0]     sc_sr_q, sc_sr_d;
  logic [12:0]     sh_sr_q, sh_sr_d;
  logic            ovf_q, ovf_d;
  logic            tick, frame_tick;
  logic [3:0]      cur_dig;

  function automatic logic [7:0] dab_adj(input logic [7:0] b);
    logic [7:0] r;
    r[3:0] = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
    r[7:4] = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  assign tick       = (presc_q == PRESC_LAST);
  assign frame_tick = tick && (idx_q == 2'd3);
  assign cur_dig    = dig_q[idx_q];

  // Odd indices are the tens digits.
  always_comb begin
    seg_d = seg7(cur_dig);
    if (BLANK_LEADING && idx_q[0] && (cur_dig == 4'd0)) seg_d = 7'h7F;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc_sr_d = sc_sr_q;
    sh_sr_d = sh_sr_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (frame_tick) state_d = LOAD;
      LOAD: begin
        ovf_d   = (score > 7'd99);
        sc_sr_d = {8'd0, (score > 7'd99) ? 7'd99 : score};
        sh_sr_d = {8'd0, shot_clock};
        cnt_d   = 3'd0;
        state_d = CONV_S;
      end
      CONV_S: begin
        sc_sr_d = {dab_adj(sc_sr_q[14:7]), sc_sr_q[6:0]} << 1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
          cnt_d   = 3'd0;
          state_d = CONV_C;
        end
      end
      CONV_C: begin
        sh_sr_d = {dab_adj(sh_sr_q[12:5]), sh_sr_q[4:0]} << 1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd4) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= LOAD;
      presc_q     <= '0;
      idx_q       <= 2'd0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
      over99_q    <= 1'b0;
      conv_done_q <= 1'b0;
      dig_q       <= '0;
      cnt_q       <= 3'd0;
      sc_sr_q     <= '0;
      sh_sr_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sc_sr_q     <= sc_sr_d;
      sh_sr_q     <= sh_sr_d;
      ovf_q       <= ovf_d;
      presc_q     <= tick ? '0 : presc_q + 1'b1;
      if (tick) idx_q <= idx_q + 2'd1;
      // Anodes dark for one cycle after each tick while seg settles on the new digit.
      an_q        <= tick ? 4'hF : ~(4'b0001 << idx_q);
      seg_q       <= seg_d;
      conv_done_q <= (state_q == COMMIT);
      if (state_q == COMMIT) begin
        dig_q    <= {sc_sr_q[14:11], sc_sr_q[10:7], sh_sr_q[12:9], sh_sr_q[8:5]};
        over99_q <= ovf_q;
      end
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign over99    = over99_q;
  assign conv_done = conv_done_q;

  a_frame_in_idle: assert property (@(posedge clk) disable iff (!clr_n) frame_tick |-> state_q == IDLE);

endmodule

// File: tb/tb_placar_display_scan.sv
// Randomized + directed bench for placar_display_scan with a queued reference model and a conv_done-driven monitor.
module tb_placar_display_scan;

  typedef struct packed {
    logic [3:0][6:0] sb;
    logic [3:0][6:0] sn;
    logic            ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [6:0] score = '0;
  logic [4:0] shot_clock = '0;
  logic [6:0] seg_b, seg_n;
  logic [3:0] an_b, an_n;
  logic       ov_b, ov_n, cd_b, cd_n;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   mon_busy = 1'b0;
  exp_t q[$];
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  placar_display_scan #(.SCAN_DIV(16), .BLANK_LEADING(1'b1)) u_b (
    .clk(clk), .clr_n(clr_n), .score(score), .shot_clock(shot_clock),
    .seg(seg_b), .an(an_b), .over99(ov_b), .conv_done(cd_b));

  placar_display_scan #(.SCAN_DIV(16), .BLANK_LEADING(1'b0)) u_n (
    .clk(clk), .clr_n(clr_n), .score(score), .shot_clock(shot_clock),
    .seg(seg_n), .an(an_n), .over99(ov_n), .conv_done(cd_n));

  // Cycles since reset release; scan position and frame starts follow from it.
  always @(posedge clk) cyc <= clr_n ? cyc + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int s, input int sh);
    exp_t e;
    int   v;
    int   d[4];
    v    = (s > 99) ? 99 : s;
    d[3] = v / 10;
    d[2] = v % 10;
    d[1] = sh / 10;
    d[0] = sh % 10;
    for (int i = 0; i < 4; i++) begin
      e.sn[i] = seg_tbl[d[i]];
      e.sb[i] = ((i % 2 == 1) && d[i] == 0) ? 7'h7F : seg_tbl[d[i]];
    end
    e.ov = (s > 99);
    return e;
  endfunction

  always @(negedge clk) begin : scan_check
    logic [3:0] e;
    if (clr_n) begin
      if (cyc % 16 == 0) e = 4'hF;
      else               e = ~(4'b0001 << ((cyc / 16) % 4));
      check("an_scan", an_b, e);
      check("an_scan_nb", an_n, e);
    end
  end

  always begin : monitor
    exp_t            e;
    logic [3:0]      got, m;
    logic [3:0][6:0] sb, sn;
    @(negedge clk);
    if (clr_n && cd_b) begin
      mon_busy = 1'b1;
      check("conv_done_nb", cd_n, 1);
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_conv_done: queue depth 0, required at least 1 (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("over99", ov_b, e.ov);
        check("over99_nb", ov_n, e.ov);
        repeat (2) @(negedge clk);
        got = '0;
        sb  = '0;
        sn  = '0;
        for (int k = 0; k < 200; k++) begin
          for (int d = 0; d < 4; d++) begin
            m = ~(4'b0001 << d);
            if (!got[d] && an_b == m) begin
              sb[d]  = seg_b;
              sn[d]  = seg_n;
              got[d] = 1'b1;
            end
          end
          if (got == 4'hF) break;
          @(negedge clk);
        end
        check("digits_seen", got, 4'hF);
        for (int d = 0; d < 4; d++) begin
          check($sformatf("seg_blank_d%0d", d), sb[d], e.sb[d]);
          check($sformatf("seg_noblank_d%0d", d), sn[d], e.sn[d]);
        end
      end
      mon_busy = 1'b0;
    end
  end

  task automatic wait_cyc_mod(input int m, input int r);
    do @(negedge clk); while (cyc % m != r);
  endtask

  task automatic do_conv(input int s, input int sh, input bit push, input bit jen, input int junk);
    wait_cyc_mod(64, 0);
    score      = 7'(s);
    shot_clock = 5'(sh);
    if (push) q.push_back(model(s, sh));
    if (jen) begin
      wait_cyc_mod(64, 4);
      score = 7'(junk);
    end
  endtask

  task automatic reset_release(input int s, input int sh);
    int lat;
    score      = 7'(s);
    shot_clock = 5'(sh);
    q.push_back(model(s, sh));
    clr_n = 1'b1;
    lat   = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (cd_b) begin
        lat = n;
        break;
      end
    end
    check("conv_latency", lat, 14);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, an_b, 4'hF);
    check({tag, "_seg"}, seg_b, 7'h7F);
    check({tag, "_over99"}, ov_b, 1'b0);
    check({tag, "_conv_done"}, cd_b, 1'b0);
  endtask

  initial begin
    int rs, rh;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_release(0, 24);
    do_conv(57, 14, 1, 0, 0);
    do_conv(120, 14, 1, 0, 0);
    do_conv(99, 14, 1, 0, 0);
    do_conv(5, 3, 1, 0, 0);
    do_conv(10, 7, 1, 1, 42);
    do_conv(42, 7, 1, 0, 0);
    do_conv(127, 31, 1, 0, 0);
    do_conv(100, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      rs = int'($urandom_range(127, 0));
      rh = int'($urandom_range(31, 0));
      do_conv(rs, rh, 1, 0, 0);
    end

    // Abort inside the shot-clock conversion; no commit is expected from it.
    do_conv(77, 30, 0, 0, 0);
    wait_cyc_mod(64, 10);
    clr_n = 1'b0;
    #1;
    check_reset_outputs("rst_conv");
    repeat (3) @(negedge clk);
    reset_release(120, 31);

    // Abort while a digit is lit and over99 is showing.
    do_conv(120, 31, 0, 0, 0);
    wait_cyc_mod(16, 5);
    check("over99_before_reset", ov_b, 1'b1);
    clr_n = 1'b0;
    #1;
    check_reset_outputs("rst_scan");
    repeat (2) @(negedge clk);
    reset_release(33, 9);

    for (int k = 0; k < 400; k++) begin
      if (q.size() == 0 && !mon_busy) break;
      @(negedge clk);
    end
    check("scoreboard_drained", (q.size() == 0 && !mon_busy), 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
